// File: rtl/cpu_pkg.sv
// Shared datapath constants: bus source codes, enable bit map, ALU op codes
// and the index layout of the generic register bank.
package cpu_pkg;

   localparam int RD_W  = 4;
   localparam int EN_W  = 16;
   localparam int ALU_W = 3;

   localparam logic [RD_W-1:0] RD_ZERO = 4'd0;
   localparam logic [RD_W-1:0] RD_PC   = 4'd1;
   localparam logic [RD_W-1:0] RD_AR   = 4'd2;
   localparam logic [RD_W-1:0] RD_IR   = 4'd4;
   localparam logic [RD_W-1:0] RD_AC   = 4'd5;
   localparam logic [RD_W-1:0] RD_R    = 4'd6;
   localparam logic [RD_W-1:0] RD_R1   = 4'd7;
   localparam logic [RD_W-1:0] RD_R2   = 4'd8;
   localparam logic [RD_W-1:0] RD_R3   = 4'd9;
   localparam logic [RD_W-1:0] RD_R4   = 4'd10;
   localparam logic [RD_W-1:0] RD_DM   = 4'd12;
   localparam logic [RD_W-1:0] RD_IM   = 4'd13;

   localparam int EN_PC = 1;
   localparam int EN_AR = 2;
   localparam int EN_IR = 3;
   localparam int EN_AC = 4;
   localparam int EN_R  = 5;
   localparam int EN_R4 = 7;
   localparam int EN_R3 = 8;
   localparam int EN_R2 = 9;
   localparam int EN_R1 = 10;
   localparam int EN_DM = 11;

   localparam logic [ALU_W-1:0] ALU_NOP = 3'd0;
   localparam logic [ALU_W-1:0] ALU_ADD = 3'd1;
   localparam logic [ALU_W-1:0] ALU_SUB = 3'd2;
   localparam logic [ALU_W-1:0] ALU_MUL = 3'd3;
   localparam logic [ALU_W-1:0] ALU_LSH = 3'd4;

   // Slots of the dp_reg bank (AC lives outside it because of the ALU)
   localparam int NUM_REGS = 8;
   localparam int REG_PC = 0;
   localparam int REG_AR = 1;
   localparam int REG_IR = 2;
   localparam int REG_R  = 3;
   localparam int REG_R1 = 4;
   localparam int REG_R2 = 5;
   localparam int REG_R3 = 6;
   localparam int REG_R4 = 7;

   function automatic int reg_en_bit(input int slot);
      case (slot)
         REG_PC:  return EN_PC;
         REG_AR:  return EN_AR;
         REG_IR:  return EN_IR;
         REG_R:   return EN_R;
         REG_R1:  return EN_R1;
         REG_R2:  return EN_R2;
         REG_R3:  return EN_R3;
         REG_R4:  return EN_R4;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/datapath_bus_if.sv
// Control/status bundle between the control FSM (master) and the datapath
// (slave), including the instruction- and data-memory ports.
interface datapath_bus_if
   import cpu_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 16
);
   logic [RD_W-1:0]   read_en;
   logic [EN_W-1:0]   write_en;
   logic [EN_W-1:0]   inc_en;
   logic [EN_W-1:0]   clr_en;
   logic [ALU_W-1:0]  alu_op;
   logic [WIDTH-1:0]  im_rdata;
   logic [WIDTH-1:0]  dm_rdata;
   logic [ADDR_W-1:0] im_addr;
   logic [ADDR_W-1:0] dm_addr;
   logic [WIDTH-1:0]  dm_wdata;
   logic              dm_we;
   logic [WIDTH-1:0]  instruction;
   logic [15:0]       z;
   logic [WIDTH-1:0]  bus;

   modport master (
      output read_en, write_en, inc_en, clr_en, alu_op, im_rdata, dm_rdata,
      input  im_addr, dm_addr, dm_wdata, dm_we, instruction, z, bus
   );

   modport slave (
      input  read_en, write_en, inc_en, clr_en, alu_op, im_rdata, dm_rdata,
      output im_addr, dm_addr, dm_wdata, dm_we, instruction, z, bus
   );
endinterface

// File: rtl/dp_reg.sv
// Generic datapath register: synchronous reset, then clear > load > increment.
module dp_reg #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic             inc,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] q_reg;

   always_ff @(posedge clk) begin
      if (rst)       q_reg <= '0;
      else if (clr)  q_reg <= '0;
      else if (load) q_reg <= d;
      else if (inc)  q_reg <= q_reg + WIDTH'(1);
   end

   assign q = q_reg;
endmodule

// File: rtl/datapath_bus.sv
// Processor datapath: register bank, shared bus mux, AC with ALU, memory ports.
// Define DATAPATH_MULT_EN to build the alu_op 3 multiplier; otherwise op 3 is a no-op.
module datapath_bus
   import cpu_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 16
) (
   input logic          clk,
   input logic          rst,
   datapath_bus_if.slave dp
);
   logic [WIDTH-1:0] reg_q [NUM_REGS];
   logic [WIDTH-1:0] bus_val;
   logic [WIDTH-1:0] ac_reg, ac_next;
   logic             carry_reg, carry_next;
   logic             unused_bits;

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
         localparam int EN = reg_en_bit(gi);
         dp_reg #(.WIDTH(WIDTH)) u_reg (
            .clk  (clk),
            .rst  (rst),
            .clr  (dp.clr_en[EN]),
            .load (dp.write_en[EN]),
            .inc  (dp.inc_en[EN]),
            .d    (bus_val),
            .q    (reg_q[gi])
         );
      end
   endgenerate

   always_comb begin
      bus_val = '0;
      case (dp.read_en)
         RD_PC:   bus_val = reg_q[REG_PC];
         RD_AR:   bus_val = reg_q[REG_AR];
         RD_IR:   bus_val = reg_q[REG_IR];
         RD_AC:   bus_val = ac_reg;
         RD_R:    bus_val = reg_q[REG_R];
         RD_R1:   bus_val = reg_q[REG_R1];
         RD_R2:   bus_val = reg_q[REG_R2];
         RD_R3:   bus_val = reg_q[REG_R3];
         RD_R4:   bus_val = reg_q[REG_R4];
         RD_DM:   bus_val = dp.dm_rdata;
         RD_IM:   bus_val = dp.im_rdata;
         default: bus_val = '0;
      endcase
   end

   // The ALU only gets AC when the FSM asserts none of AC's own enables
   always_comb begin
      ac_next    = ac_reg;
      carry_next = carry_reg;
      if (dp.clr_en[EN_AC]) begin
         ac_next = '0;
      end else if (dp.write_en[EN_AC]) begin
         ac_next = bus_val;
      end else if (dp.inc_en[EN_AC]) begin
         ac_next = ac_reg + WIDTH'(1);
      end else begin
         case (dp.alu_op)
            ALU_ADD: {carry_next, ac_next} = {1'b0, ac_reg} + {1'b0, reg_q[REG_R]};
            ALU_SUB: {carry_next, ac_next} = {1'b0, ac_reg} - {1'b0, reg_q[REG_R]};
`ifdef DATAPATH_MULT_EN
            ALU_MUL: ac_next = ac_reg * reg_q[REG_R];
`endif
            ALU_LSH: begin
               ac_next    = {ac_reg[WIDTH-2:0], 1'b0};
               carry_next = ac_reg[WIDTH-1];
            end
            default: ac_next = ac_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ac_reg    <= '0;
         carry_reg <= 1'b0;
      end else begin
         ac_reg    <= ac_next;
         carry_reg <= carry_next;
      end
   end

   assign dp.bus         = bus_val;
   assign dp.dm_wdata    = bus_val;
   assign dp.dm_we       = dp.write_en[EN_DM];
   assign dp.im_addr     = reg_q[REG_PC][ADDR_W-1:0];
   assign dp.dm_addr     = reg_q[REG_AR][ADDR_W-1:0];
   assign dp.instruction = reg_q[REG_IR];
   assign dp.z           = (ac_reg == '0) ? 16'd1 : 16'd0;

   // Carry has no consumer yet; the enable bits listed here map to no register
   assign unused_bits = ^{carry_reg,
                          dp.write_en[15:12], dp.write_en[6], dp.write_en[0],
                          dp.inc_en[15:12],   dp.inc_en[11],  dp.inc_en[6], dp.inc_en[0],
                          dp.clr_en[15:12],   dp.clr_en[11],  dp.clr_en[6], dp.clr_en[0]};
endmodule

// File: doc/datapath_bus.md
Name: datapath_bus

Overview:
- Datapath responder to the processor control FSM.
- Holds the architectural registers PC, AR, IR, AC, R, R1-R4 and the shared 16-bit bus mux.
- Applies the FSM's one-hot write/increment/clear enables, executes ALU ops into AC, and drives the instruction-memory and data-memory ports.
- Returns `instruction` (IR) and the zero flag `z` to the control FSM.

Parameters:
- WIDTH, 16, data width of every register and the bus.
- ADDR_W, 16, width of the im_addr and dm_addr ports (low bits of PC/AR).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- read_en  in  4  bus source select code
- write_en  in  16  one-hot-per-bit register load enables from bus
- inc_en  in  16  per-register increment enables (same bit map)
- clr_en  in  16  per-register clear enables (same bit map)
- alu_op  in  3  ALU operation into AC
- im_rdata  in  WIDTH  instruction memory read data (combinational)
- dm_rdata  in  WIDTH  data memory read data (combinational)
- im_addr  out  ADDR_W  = PC
- dm_addr  out  ADDR_W  = AR
- dm_wdata  out  WIDTH  = bus
- dm_we  out  1  = write_en[11]
- instruction  out  WIDTH  = IR
- z  out  16  16'd1 when AC==0, else 16'd0
- bus  out  WIDTH  current bus value (debug/observation)

Behaviour:
- Enable bit map, shared by write_en, inc_en and clr_en: 11 DM, 10 R1, 9 R2, 8 R3, 7 R4, 5 R, 4 AC, 3 IR, 2 AR, 1 PC. Bits 15:12, 6 and 0 are ignored.
- read_en codes:
  - 0 → bus = 0
  - 1 PC, 2 AR, 4 IR, 5 AC, 6 R, 7 R1, 8 R2, 9 R3, 10 R4
  - 12 dm_rdata, 13 im_rdata
  - 3, 11, 14, 15 → bus = 0
- Per-register update each rising clk, priority highest first: clr (→0), write (←bus), inc (+1, wraps 16'hFFFF→0), hold.
- AC priority is clr > write > inc > ALU.
- ALU, applied only when no AC enable is set:
  - alu_op 1: AC ← AC+R
  - alu_op 2: AC ← AC−R
  - alu_op 3: AC ← low 16 bits of AC*R
  - alu_op 4: AC ← AC<<1
  - alu_op 0, 5-7: no change
  - All results are modulo 2^16.
- carry: internal register, updated only on ALU ops 1/2/4:
  - op 1: carry-out of the add
  - op 2: borrow
  - op 4: bit 15 shifted out
- Latency: a register loaded at edge N is visible on the bus and outputs after edge N. bus, dm_we, dm_wdata, im_addr, dm_addr and z are combinational from current state and inputs.
- Same-edge read/write: a register that is both bus source and write target reloads its own old value. Example: read_en=5 with write_en[4] set leaves AC unchanged.
- Multiple write_en bits set: all selected registers load the same bus value, which is legal.
- rst: every register, including carry, is 0 on the next edge; rst overrides all enables.
  - Outputs after reset: im_addr=0, dm_addr=0, instruction=0, z=16'd1, dm_we follows write_en[11] combinationally, bus=0 when read_en=0.
  - Reset asserted mid-instruction discards that instruction with no partial update.

Optional Feature:
- DATAPATH_MULT_EN defined: alu_op 3 performs a 16x16 multiply and writes the low half to AC.
- Not defined: alu_op 3 is a no-op (AC and carry unchanged) and no multiplier is synthesised.

Decomposition:
- Package cpu_pkg holds:
  - read_en source codes
  - enable bit indices (EN_PC, EN_AR, EN_IR, EN_AC, EN_R, EN_R4..EN_R1, EN_DM)
  - alu_op codes (ALU_NOP, ALU_ADD, ALU_SUB, ALU_MUL, ALU_LSH)
- One sub-module, dp_reg: a WIDTH-bit register with sync rst, clr, load, inc in that priority. It is instantiated for PC, AR, IR, R, R1-R4.
- AC stays inline in datapath_bus because of its ALU path.

Test Plan:
- Fetch: rst, then read_en=13, write_en[3], im_rdata=16'h0013 → IR=16'h0013. Next cycle inc_en[1] → PC=1, im_addr=1.
- Add/sub: AC=5 loaded from dm_rdata, R=3 via read_en=5/write_en[5], AC loaded 5 again; alu_op=1 → AC=8; alu_op=2 with R=8 → AC=0, z=16'd1.
- Store: AR=16'h0040, AC=16'h1234, read_en=5, write_en[11] → dm_we=1, dm_addr=16'h0040, dm_wdata=16'h1234 for exactly that cycle.
- Priority/wrap: AC=16'hFFFF with inc_en[4] → AC=0, z=1. Same cycle as clr_en[4] plus write_en[4] → AC=0.
- Multiply: AC=16'h0100, R=16'h0101, alu_op=3 → AC=16'h0100 with DATAPATH_MULT_EN; AC unchanged without it.
- Reset mid-op: alu_op=1 and rst high in the same cycle → all registers 0, z=16'd1, no ALU result.
